// File: rtl/servo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : servo_pkg
//  Description : Shared types and default constants for the servo path
//                (mode FSM, slew limiter, PWM generators).
//  Revision    : 1.0  initial release
// ============================================================================
package servo_pkg;

  // Slew limiter sequencing state
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    MOVE = 1'b1
  } state_t;

  // Default position constants shared across the servo blocks
  localparam int DATA_WIDTH_DEF = 16;
  localparam int POS_INIT_DEF   = 90;
  localparam int POS_MAX_DEF    = 180;

endpackage
`default_nettype wire

// File: rtl/servo_slew_limiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : servo_slew_limiter_if
//  Description : Valid/ready target-set channel into the slew limiter.
//  Revision    : 1.0  initial release
// ============================================================================
interface servo_slew_limiter_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  tgt_valid;
  logic                  tgt_ready;
  logic [DATA_WIDTH-1:0] tgt_x;
  logic [DATA_WIDTH-1:0] tgt_y;
  logic [DATA_WIDTH-1:0] tgt_z;

  modport master (output tgt_valid, tgt_x, tgt_y, tgt_z, input tgt_ready);
  modport slave  (input tgt_valid, tgt_x, tgt_y, tgt_z, output tgt_ready);
endinterface
`default_nettype wire

// File: rtl/servo_axis_stepper.sv
`default_nettype none
// ============================================================================
//  Module      : servo_axis_stepper
//  Description : One axis of the slew limiter. Holds the current position and
//                moves it toward the target by at most STEP codes per step.
//  Revision    : 1.0  initial release
// ============================================================================
module servo_axis_stepper #(
  parameter int DATA_WIDTH = 16,
  parameter int STEP       = 1,
  parameter int POS_INIT   = 90
) (
  input  wire logic                  clk,
  input  wire logic                  rst_n,
  input  wire logic                  step_en,
  input  wire logic [DATA_WIDTH-1:0] tgt,
  output logic      [DATA_WIDTH-1:0] pos,
  output logic                       at_target,
  output logic                       last_step
);

  localparam logic [DATA_WIDTH-1:0] STEP_C = DATA_WIDTH'(STEP);
  localparam logic [DATA_WIDTH-1:0] INIT_C = DATA_WIDTH'(POS_INIT);

  logic [DATA_WIDTH-1:0] pos_r;
  logic [DATA_WIDTH-1:0] diff;
  logic [DATA_WIDTH-1:0] delta;
  logic                  below;

  // Unsigned distance to target (larger minus smaller, never wraps)
  // and the bounded step size
  always_comb begin
    below = pos_r < tgt;
    diff  = below ? (tgt - pos_r) : (pos_r - tgt);
    delta = (diff > STEP_C) ? STEP_C : diff;
  end

  // Position register: one bounded step per enabled tick
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_r <= INIT_C;
    end else if (step_en) begin
      if (below) pos_r <= pos_r + delta;
      else       pos_r <= pos_r - delta;
    end
  end

  assign pos       = pos_r;
  assign at_target = (pos_r == tgt);
  // This step lands exactly on the target (or it is already there)
  assign last_step = (diff <= STEP_C);

endmodule
`default_nettype wire

// File: rtl/servo_slew_limiter.sv
`default_nettype none
// ============================================================================
//  Module      : servo_slew_limiter
//  Description : Rate-limits three servo position commands. Captures a clamped
//                target set, walks each axis toward it by at most STEP codes
//                per tick, and buffers one further set while a move runs.
//  Revision    : 1.0  initial release
// ============================================================================
module servo_slew_limiter
  import servo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int TICK_DIV   = 500000,
  parameter int STEP       = 1,
  parameter int POS_MAX    = POS_MAX_DEF,
  parameter int POS_INIT   = POS_INIT_DEF
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic             en,
  servo_slew_limiter_if.slave   tgt,
  output logic [DATA_WIDTH-1:0] pos_x,
  output logic [DATA_WIDTH-1:0] pos_y,
  output logic [DATA_WIDTH-1:0] pos_z,
  output logic                  settled
);

  localparam int                    CNT_W  = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [DATA_WIDTH-1:0] MAX_C  = DATA_WIDTH'(POS_MAX);
  localparam logic [DATA_WIDTH-1:0] INIT_C = DATA_WIDTH'(POS_INIT);

  function automatic logic [DATA_WIDTH-1:0] clamp(input logic [DATA_WIDTH-1:0] v);
    return (v > MAX_C) ? MAX_C : v;
  endfunction

  state_t                     state;
  logic [CNT_W-1:0]           cnt;
  logic                       pend_valid;
  logic [2:0][DATA_WIDTH-1:0] tgt_r;
  logic [2:0][DATA_WIDTH-1:0] pend_r;
  logic [2:0][DATA_WIDTH-1:0] set_c;
  logic [2:0][DATA_WIDTH-1:0] pos_w;
  logic [2:0]                 last_step;
  logic [2:0]                 at_target_unused;

  logic tick;
  logic step_en;
  logic done;
  logic xfer;
  logic set_eq_pos;
  logic set_eq_tgt;

  assign set_c[0] = clamp(tgt.tgt_x);
  assign set_c[1] = clamp(tgt.tgt_y);
  assign set_c[2] = clamp(tgt.tgt_z);

  assign tgt.tgt_ready = !pend_valid;
  assign xfer          = tgt.tgt_valid && !pend_valid;
  assign tick          = en && (cnt == CNT_LAST);
  assign step_en       = tick && (state == MOVE);
  assign done          = step_en && (&last_step);
  assign set_eq_pos    = (set_c == pos_w);
  // On completion the new positions equal the old targets
  assign set_eq_tgt    = (set_c == tgt_r);

  // Tick prescaler: free-runs while enabled, held at zero otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               cnt <= '0;
    else if (!en)             cnt <= '0;
    else if (cnt == CNT_LAST) cnt <= '0;
    else                      cnt <= cnt + 1'b1;
  end

  // IDLE/MOVE sequencer with target and one-deep pending register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      pend_valid <= 1'b0;
      tgt_r      <= {3{INIT_C}};
      pend_r     <= {3{INIT_C}};
    end else begin
      case (state)
        IDLE: begin
          if (xfer) begin
            tgt_r <= set_c;
            state <= set_eq_pos ? IDLE : MOVE;
          end
        end
        MOVE: begin
          if (done) begin
            if (pend_valid) begin
              tgt_r      <= pend_r;
              pend_valid <= 1'b0;
            end else if (xfer) begin
              tgt_r <= set_c;
              state <= set_eq_tgt ? IDLE : MOVE;
            end else begin
              state <= IDLE;
            end
          end else if (xfer) begin
            pend_r     <= set_c;
            pend_valid <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  generate
    for (genvar a = 0; a < 3; a++) begin : g_axis
      servo_axis_stepper #(
        .DATA_WIDTH (DATA_WIDTH),
        .STEP       (STEP),
        .POS_INIT   (POS_INIT)
      ) u_axis (
        .clk       (clk),
        .rst_n     (rst_n),
        .step_en   (step_en),
        .tgt       (tgt_r[a]),
        .pos       (pos_w[a]),
        .at_target (at_target_unused[a]),
        .last_step (last_step[a])
      );
    end
  endgenerate

  assign pos_x   = pos_w[0];
  assign pos_y   = pos_w[1];
  assign pos_z   = pos_w[2];
  assign settled = (state == IDLE) && !pend_valid;

endmodule
`default_nettype wire

// File: tb/tb_servo_slew_limiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_servo_slew_limiter
//  Description : Directed self-checking bench for servo_slew_limiter
//                (TICK_DIV = 4, STEP = 2, POS_MAX = 180, POS_INIT = 90).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_servo_slew_limiter;

  localparam int W = 16;

  logic         clk;
  logic         rst_n;
  logic         en;
  logic [W-1:0] pos_x, pos_y, pos_z;
  logic         settled;

  int n_checks;
  int n_fail;

  servo_slew_limiter_if #(.DATA_WIDTH(W)) bus ();

  servo_slew_limiter #(
    .DATA_WIDTH (W),
    .TICK_DIV   (4),
    .STEP       (2),
    .POS_MAX    (180),
    .POS_INIT   (90)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .tgt     (bus),
    .pos_x   (pos_x),
    .pos_y   (pos_y),
    .pos_z   (pos_z),
    .settled (settled)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_pos(input string tag, input int ex, input int ey, input int ez);
    check_eq({tag, "_x"}, 32'(pos_x), ex);
    check_eq({tag, "_y"}, 32'(pos_y), ey);
    check_eq({tag, "_z"}, 32'(pos_z), ez);
  endtask

  task automatic set_tgt(input int x, input int y, input int z);
    bus.tgt_x     = W'(x);
    bus.tgt_y     = W'(y);
    bus.tgt_z     = W'(z);
    bus.tgt_valid = 1'b1;
  endtask

  task automatic do_reset();
    rst_n         = 1'b0;
    en            = 1'b0;
    bus.tgt_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    bus.tgt_x = '0;
    bus.tgt_y = '0;
    bus.tgt_z = '0;
    bus.tgt_valid = 1'b0;
    en    = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);

    // ---- reset state, no motion while idle --------------------------------
    do_reset();
    check_pos("rst", 90, 90, 90);
    check_eq("rst_ready", 32'(bus.tgt_ready), 1);
    check_eq("rst_settled", 32'(settled), 1);
    en = 1'b1;
    repeat (20) begin
      @(negedge clk);
      check_pos("idle", 90, 90, 90);
      check_eq("idle_settled", 32'(settled), 1);
    end

    // ---- basic move (100,80,91) -------------------------------------------
    do_reset();
    en = 1'b1;
    set_tgt(100, 80, 91);
    @(negedge clk);
    bus.tgt_valid = 1'b0;
    check_eq("mv_ready", 32'(bus.tgt_ready), 1);
    check_eq("mv_busy", 32'(settled), 0);
    check_pos("mv_cap", 90, 90, 90);
    repeat (2) @(negedge clk);
    check_pos("mv_pre", 90, 90, 90);
    @(negedge clk);
    check_pos("mv_t1", 92, 88, 91);
    for (int k = 2; k <= 5; k++) begin
      repeat (4) @(negedge clk);
      check_pos("mv_tk", 90 + 2 * k, 90 - 2 * k, 91);
      check_eq("mv_settled", 32'(settled), (k == 5) ? 1 : 0);
    end

    // ---- clamp and no underflow (250,0,90) --------------------------------
    do_reset();
    en = 1'b1;
    set_tgt(250, 0, 90);
    @(negedge clk);
    bus.tgt_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_pos("cl_t1", 92, 88, 90);
    repeat (43 * 4) @(negedge clk);
    check_pos("cl_t44", 178, 2, 90);
    check_eq("cl_t44_settled", 32'(settled), 0);
    repeat (4) @(negedge clk);
    check_pos("cl_t45", 180, 0, 90);
    check_eq("cl_t45_settled", 32'(settled), 1);
    repeat (8) @(negedge clk);
    check_pos("cl_hold", 180, 0, 90);

    // ---- pending target, third held off -----------------------------------
    do_reset();
    en = 1'b1;
    set_tgt(96, 90, 90);
    @(negedge clk);
    bus.tgt_valid = 1'b0;
    check_eq("pd_ready_a", 32'(bus.tgt_ready), 1);
    repeat (3) @(negedge clk);
    check_pos("pd_t1", 92, 90, 90);
    set_tgt(100, 86, 90);
    @(negedge clk);
    check_eq("pd_ready_b", 32'(bus.tgt_ready), 0);
    set_tgt(50, 50, 50);
    repeat (6) begin
      @(negedge clk);
      check_eq("pd_held", 32'(bus.tgt_ready), 0);
      check_eq("pd_noidle", 32'(settled), 0);
    end
    check_pos("pd_t2", 94, 90, 90);
    @(negedge clk);
    check_pos("pd_t3", 96, 90, 90);
    check_eq("pd_promote_ready", 32'(bus.tgt_ready), 1);
    check_eq("pd_promote_busy", 32'(settled), 0);
    bus.tgt_valid = 1'b0;
    repeat (4) @(negedge clk);
    check_pos("pd_b1", 98, 88, 90);
    repeat (4) @(negedge clk);
    check_pos("pd_b2", 100, 86, 90);
    check_eq("pd_done", 32'(settled), 1);

    // ---- freeze with en low -----------------------------------------------
    en = 1'b0;
    @(negedge clk);
    en = 1'b1;
    set_tgt(110, 86, 90);
    @(negedge clk);
    bus.tgt_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_pos("fr_t1", 102, 86, 90);
    repeat (4) @(negedge clk);
    check_pos("fr_t2", 104, 86, 90);
    @(negedge clk);
    en = 1'b0;
    repeat (50) begin
      @(negedge clk);
      check_eq("fr_frozen", 32'(pos_x), 104);
    end
    en = 1'b1;
    repeat (3) @(negedge clk);
    check_pos("fr_pre", 104, 86, 90);
    @(negedge clk);
    check_pos("fr_resume", 106, 86, 90);

    // ---- async reset mid-move with a pending set --------------------------
    set_tgt(60, 60, 60);
    @(negedge clk);
    bus.tgt_valid = 1'b0;
    check_eq("ar_pend", 32'(bus.tgt_ready), 0);
    #2 rst_n = 1'b0;
    #1;
    check_pos("ar_async", 90, 90, 90);
    check_eq("ar_ready", 32'(bus.tgt_ready), 1);
    check_eq("ar_settled", 32'(settled), 1);
    @(negedge clk);
    rst_n = 1'b1;
    en    = 1'b1;
    repeat (40) @(negedge clk);
    check_pos("ar_discard", 90, 90, 90);
    check_eq("ar_settled2", 32'(settled), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
